// File: rtl/mlp_dispatch_sched.sv
// Splits one input stream into BURST_LEN-word bursts for dispatchers 0..3, then reads one collector result per round.
// Input->ififo wen is 0 cycles; last word->m_res_tvalid is 3 cycles. Stalls on ififo rdy, collector rdy or a held result.
// Optional SCHED_PERF_EN adds stall_cnt (DISPATCH cycles with s_tvalid=1 and s_tready=0, saturating).
module mlp_dispatch_sched #(
    parameter int DATA_WIDTH = 64,
    parameter int RES_WIDTH  = 64,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] dispatcher0_ififo_wdata,
    output logic                  dispatcher0_ififo_wen,
    input  logic                  dispatcher0_ififo_rdy,
    output logic [DATA_WIDTH-1:0] dispatcher1_ififo_wdata,
    output logic                  dispatcher1_ififo_wen,
    input  logic                  dispatcher1_ififo_rdy,
    output logic [DATA_WIDTH-1:0] dispatcher2_ififo_wdata,
    output logic                  dispatcher2_ififo_wen,
    input  logic                  dispatcher2_ififo_rdy,
    output logic [DATA_WIDTH-1:0] dispatcher3_ififo_wdata,
    output logic                  dispatcher3_ififo_wen,
    input  logic                  dispatcher3_ififo_rdy,
    input  logic [RES_WIDTH-1:0]  collector_ofifo_rdata,
    output logic                  collector_ofifo_ren,
    input  logic                  collector_ofifo_rdy,
    output logic [RES_WIDTH-1:0]  m_res_tdata,
    output logic                  m_res_tvalid,
    input  logic                  m_res_tready,
`ifdef SCHED_PERF_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic [15:0]           round_cnt
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_READ, S_CAPTURE} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_sel, w_sel_nxt;
    logic [CW-1:0]        r_word_cnt, w_word_cnt_nxt;
    logic                 r_res_valid;
    logic [RES_WIDTH-1:0] r_res_data;
    logic [15:0]          r_round_cnt;
    logic [3:0]           w_rdy;
    logic [3:0]           w_wen;
    logic                 w_tready;
    logic                 w_ren;

    assign w_rdy = {dispatcher3_ififo_rdy, dispatcher2_ififo_rdy,
                    dispatcher1_ififo_rdy, dispatcher0_ififo_rdy};

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_word_cnt_nxt = r_word_cnt;
        w_tready       = 1'b0;
        w_wen          = 4'b0000;
        w_ren          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel_nxt      = 2'd0;
                w_word_cnt_nxt = '0;
                if (en) w_state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                w_tready = w_rdy[r_sel];
                if (s_tvalid && w_rdy[r_sel]) begin
                    w_wen[r_sel] = 1'b1;
                    if (r_word_cnt == LAST_WORD) begin
                        w_word_cnt_nxt = '0;
                        w_sel_nxt      = r_sel + 2'd1;
                        if (r_sel == 2'd3) w_state_nxt = S_READ;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            S_READ: begin
                // A result still waiting downstream blocks the read, so the collector is never drained early.
                if (collector_ofifo_rdy && !r_res_valid) begin
                    w_ren       = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = en ? S_DISPATCH : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    // CAPTURE is only reachable with r_res_valid=0, so set and clear never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_round_cnt <= 16'd0;
        end else if (r_state == S_CAPTURE) begin
            r_res_valid <= 1'b1;
            r_res_data  <= collector_ofifo_rdata;
            r_round_cnt <= r_round_cnt + 16'd1;
        end else if (r_res_valid && m_res_tready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 32'd0;
        end else if (r_state == S_DISPATCH && s_tvalid && !w_tready && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign s_tready                = w_tready;
    assign dispatcher0_ififo_wdata = s_tdata;
    assign dispatcher1_ififo_wdata = s_tdata;
    assign dispatcher2_ififo_wdata = s_tdata;
    assign dispatcher3_ififo_wdata = s_tdata;
    assign dispatcher0_ififo_wen   = w_wen[0];
    assign dispatcher1_ififo_wen   = w_wen[1];
    assign dispatcher2_ififo_wen   = w_wen[2];
    assign dispatcher3_ififo_wen   = w_wen[3];
    assign collector_ofifo_ren     = w_ren;
    assign m_res_tdata             = r_res_data;
    assign m_res_tvalid            = r_res_valid;
    assign round_cnt               = r_round_cnt;

endmodule

// File: tb/tb_mlp_dispatch_sched.sv
// Bench for mlp_dispatch_sched: round-level reference model plus directed scenarios and randomized traffic.
module tb_mlp_dispatch_sched;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] wd [4];
    logic [3:0]  wen;
    logic [3:0]  disp_rdy;
    logic [63:0] collector_ofifo_rdata;
    logic        collector_ofifo_ren;
    logic        collector_ofifo_rdy;
    logic [63:0] m_res_tdata;
    logic        m_res_tvalid;
    logic        m_res_tready;
    logic [15:0] round_cnt;
`ifdef SCHED_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mlp_dispatch_sched #(.DATA_WIDTH(64), .RES_WIDTH(64), .BURST_LEN(BL)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .dispatcher0_ififo_wdata(wd[0]), .dispatcher0_ififo_wen(wen[0]), .dispatcher0_ififo_rdy(disp_rdy[0]),
        .dispatcher1_ififo_wdata(wd[1]), .dispatcher1_ififo_wen(wen[1]), .dispatcher1_ififo_rdy(disp_rdy[1]),
        .dispatcher2_ififo_wdata(wd[2]), .dispatcher2_ififo_wen(wen[2]), .dispatcher2_ififo_rdy(disp_rdy[2]),
        .dispatcher3_ififo_wdata(wd[3]), .dispatcher3_ififo_wen(wen[3]), .dispatcher3_ififo_rdy(disp_rdy[3]),
        .collector_ofifo_rdata(collector_ofifo_rdata), .collector_ofifo_ren(collector_ofifo_ren),
        .collector_ofifo_rdy(collector_ofifo_rdy),
        .m_res_tdata(m_res_tdata), .m_res_tvalid(m_res_tvalid), .m_res_tready(m_res_tready),
`ifdef SCHED_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .round_cnt(round_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Reference model: a round is "m_n words taken, then one collector read, then one capture".
    bit          m_active, m_rw, m_cap, m_rv;
    int          m_n;
    logic [63:0] m_rdata, m_pend;
    logic [15:0] m_round;
    bit          fixed_res;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_rw = 0; m_cap = 0; m_rv = 0;
            m_n = 0; m_rdata = '0; m_pend = '0; m_round = '0;
        end else begin
            bit acc, ren_now;
            int s;
            s = (m_n / BL > 3) ? 3 : m_n / BL;
            acc     = m_active && !m_rw && !m_cap && s_tvalid && disp_rdy[s];
            ren_now = m_active && m_rw && !m_cap && collector_ofifo_rdy && !m_rv;
            if (m_rv && m_res_tready) m_rv = 0;
            if (!m_active) begin
                if (en) begin m_active = 1; m_n = 0; end
            end else if (m_cap) begin
                m_rv = 1; m_rdata = m_pend; m_round = m_round + 16'd1;
                m_cap = 0; m_rw = 0; m_n = 0; m_active = en;
            end else if (m_rw) begin
                if (ren_now) begin
                    m_cap  = 1;
                    m_pend = fixed_res ? 64'hABCD : {$urandom, $urandom};
                end
            end else if (acc) begin
                m_n++;
                if (m_n == 4 * BL) m_rw = 1;
            end
        end
    end

    int          cyc = 0;
    int          acc_total = 0;
    bit          acc_seen = 0;
    int          ren_cnt = 0;
    logic [3:0]  last_wen = '0;
    bit          rec = 0;
    logic [63:0] dq [4][$];

    always @(negedge clk) begin
        logic [3:0] ew;
        logic       et, er;
        int         s;
        cyc++;
        s  = (m_n / BL > 3) ? 3 : m_n / BL;
        et = m_active && !m_rw && !m_cap && disp_rdy[s];
        ew = (et && s_tvalid) ? (4'b0001 << s) : 4'b0000;
        er = m_active && m_rw && !m_cap && collector_ofifo_rdy && !m_rv;
        chk("s_tready", s_tready, et);
        chk("wen", wen, ew);
        for (int k = 0; k < 4; k++) begin
            if (wen[k]) begin
                chk("wdata", wd[k], s_tdata);
                if (rec) dq[k].push_back(wd[k]);
            end
        end
        chk("ren", collector_ofifo_ren, er);
        chk("m_res_tvalid", m_res_tvalid, m_rv);
        chk("m_res_tdata", m_res_tdata, m_rdata);
        chk("round_cnt", round_cnt, m_round);
        acc_seen = s_tvalid && et;
        if (acc_seen) acc_total++;
        if (wen != 4'b0000) last_wen = wen;
        if (collector_ofifo_ren) ren_cnt++;
    end

    logic [63:0] seq = 64'd1;

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_seen) begin
            seq = seq + 64'd1;
            s_tdata = seq;
        end
        collector_ofifo_rdata = m_cap ? m_pend : (fixed_res ? 64'hABCD : {$urandom, $urandom});
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_total < target && n < 300) begin step(); n++; end
        if (acc_total < target) timeout_fail(name);
    endtask

    task automatic wait_round_change(input string name);
        logic [15:0] rc;
        int n = 0;
        rc = round_cnt;
        while (round_cnt == rc && n < 400) begin step(); n++; end
        if (round_cnt == rc) timeout_fail(name);
    endtask

    initial begin
        int first_acc_cyc, last_acc_cyc, valid_cyc, n, base;
        reset_n = 0; en = 0; s_tvalid = 0; s_tdata = 64'd1; disp_rdy = 4'b0000;
        collector_ofifo_rdy = 0; collector_ofifo_rdata = 64'hABCD; m_res_tready = 0;
        fixed_res = 1;
        #12;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_ren", collector_ofifo_ren, 0);
        chk("rst_tvalid", m_res_tvalid, 0);
        chk("rst_tdata", m_res_tdata, 0);
        chk("rst_round", round_cnt, 0);
        @(posedge clk); #1;
        reset_n = 1;
        step();

        // Directed round: 16 words 1..16, all ready, fixed collector data.
        en = 1; disp_rdy = 4'b1111; collector_ofifo_rdy = 1; m_res_tready = 1;
        s_tvalid = 1; rec = 1;
        first_acc_cyc = -1; last_acc_cyc = -1; n = 0;
        while (acc_total < 16 && n < 60) begin
            @(negedge clk); #1;
            if (acc_seen && first_acc_cyc < 0) first_acc_cyc = cyc;
            if (acc_seen && acc_total == 16) last_acc_cyc = cyc;
            step(); n++;
        end
        s_tvalid = 0; rec = 0;
        if (acc_total < 16) timeout_fail("round1_words");
        chk("zero_bubble", 64'(last_acc_cyc - first_acc_cyc), 64'd15);
        for (int k = 0; k < 4; k++) begin
            chk("disp_count", 64'(dq[k].size()), 64'd4);
            for (int j = 0; j < 4 && j < dq[k].size(); j++)
                chk("disp_word", dq[k][j], 64'(k * 4 + j + 1));
        end
        valid_cyc = -1; n = 0;
        while (valid_cyc < 0 && n < 20) begin
            @(negedge clk); #1;
            if (m_res_tvalid) valid_cyc = cyc;
            n++;
        end
        if (valid_cyc < 0) timeout_fail("round1_result");
        chk("result_latency", 64'(valid_cyc - last_acc_cyc), 64'd3);
        chk("result_data", m_res_tdata, 64'hABCD);
        chk("result_round", round_cnt, 16'd1);
        chk("ren_pulses", 64'(ren_cnt), 64'd1);
        @(negedge clk); #1;
        chk("result_one_cycle", m_res_tvalid, 0);
        step();

        // Dispatcher 2 back-pressure mid-burst.
        fixed_res = 0; s_tvalid = 1;
        wait_acc(24, "round2_to_disp2");
        disp_rdy[2] = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_tready", s_tready, 0);
            chk("stall_wen", wen, 0);
            step();
        end
        disp_rdy[2] = 1;
`ifdef SCHED_PERF_EN
        chk("stall_cnt", stall_cnt, 32'd5);
`endif
        wait_acc(32, "round2_finish");

        // Randomized traffic, including long result back-pressure and en drops.
        for (int i = 0; i < 3000; i++) begin
            step();
            en                  = ($urandom_range(0, 19) != 0);
            s_tvalid            = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) disp_rdy[k] = ($urandom_range(0, 4) != 0);
            collector_ofifo_rdy = ($urandom_range(0, 2) != 0);
            m_res_tready        = (i % 200 < 120) ? ($urandom_range(0, 9) < 4) : 1'b0;
        end

        // en dropped during dispatcher 1's burst: round completes, then idle.
        en = 1; s_tvalid = 1; disp_rdy = 4'b1111; collector_ofifo_rdy = 1; m_res_tready = 1;
        wait_round_change("align_round");
        base = acc_total;
        wait_acc(base + 5, "en_drop_disp1");
        en = 0;
        wait_round_change("en_drop_round");
        for (int i = 0; i < 3; i++) step();
        @(negedge clk); #1;
        chk("idle_tready", s_tready, 0);
        chk("idle_wen", wen, 0);
        step();

        // Asynchronous reset mid-burst, then restart at dispatcher 0.
        en = 1;
        base = acc_total;
        wait_acc(base + 2, "pre_reset_words");
        #3 reset_n = 0;
        #1;
        chk("arst_tready", s_tready, 0);
        chk("arst_wen", wen, 0);
        chk("arst_ren", collector_ofifo_ren, 0);
        chk("arst_tvalid", m_res_tvalid, 0);
        chk("arst_tdata", m_res_tdata, 0);
        chk("arst_round", round_cnt, 0);
        step();
        reset_n = 1;
        last_wen = '0;
        base = acc_total;
        wait_acc(base + 1, "restart_word");
        chk("restart_disp0", last_wen, 4'b0001);
        wait_acc(base + 5, "restart_disp1");
        chk("restart_next_disp", last_wen, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
